// File: rtl/fifo_sync_wconv.sv
// fifo_sync_wconv: single-clock FIFO with asymmetric write/read widths; storage and pointers in narrow-word units.
// Optional macro FIFO_WCONV_FWFT_EN selects first-word-fall-through reads; default is a registered Q with 1-cycle latency.
module fifo_sync_wconv #(
    parameter int DWI      = 4,
    parameter int DWO      = 16,
    parameter int DEPTH    = 32,
    parameter int AF_LEVEL = 24
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         WR_EN,
    input  logic [DWI-1:0]               D,
    output logic                         WR_FULL,
    output logic                         WR_ALMOST_FULL,
    output logic                         OVERFLOW,
    input  logic                         RD_EN,
    output logic [DWO-1:0]               Q,
    output logic                         Q_VALID,
    output logic                         RD_EMPTY,
    output logic                         UNDERFLOW,
    output logic [$clog2(DEPTH):0]       LEVEL
);
    localparam int DWN = (DWI < DWO) ? DWI : DWO;
    localparam int NI  = DWI / DWN;
    localparam int NO  = DWO / DWN;
    localparam int AW  = $clog2(DEPTH);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] NI_C    = (AW+1)'(NI);
    localparam logic [AW:0] NO_C    = (AW+1)'(NO);
    localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);

    logic [DWN-1:0] mem [DEPTH];

    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic [AW:0]    level_q;
    logic           wr_full_q;
    logic           rd_empty_q;
    logic           af_q;
    logic           ovf_q;
    logic           udf_q;

    logic           wr_acc;
    logic           rd_acc;
    logic [AW:0]    wr_ptr_nxt;
    logic [AW:0]    rd_ptr_nxt;
    logic [AW:0]    level_nxt;
    logic [DWO-1:0] rd_word;

    // Both requests are qualified against the flags as they stand before the edge.
    assign wr_acc     = WR_EN && !wr_full_q;
    assign rd_acc     = RD_EN && !rd_empty_q;
    assign wr_ptr_nxt = wr_acc ? (wr_ptr + NI_C) : wr_ptr;
    assign rd_ptr_nxt = rd_acc ? (rd_ptr + NO_C) : rd_ptr;
    assign level_nxt  = wr_ptr_nxt - rd_ptr_nxt;

    // Oldest narrow word lands in the least-significant slice of the read word.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NO; i++) begin
            rd_word[i*DWN +: DWN] = mem[rd_ptr[AW-1:0] + AW'(i)];
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_acc) begin
            for (int i = 0; i < NI; i++) begin
                mem[wr_ptr[AW-1:0] + AW'(i)] <= D[i*DWN +: DWN];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            wr_full_q  <= 1'b0;
            rd_empty_q <= 1'b1;
            af_q       <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
            level_q    <= level_nxt;
            wr_full_q  <= (DEPTH_C - level_nxt) < NI_C;
            rd_empty_q <= level_nxt < NO_C;
            af_q       <= level_nxt >= AF_C;
            ovf_q      <= WR_EN && wr_full_q;
            udf_q      <= RD_EN && rd_empty_q;
        end
    end

    assign WR_FULL        = wr_full_q;
    assign WR_ALMOST_FULL = af_q;
    assign OVERFLOW       = ovf_q;
    assign RD_EMPTY       = rd_empty_q;
    assign UNDERFLOW      = udf_q;
    assign LEVEL          = level_q;

`ifdef FIFO_WCONV_FWFT_EN
    assign Q       = rd_word;
    assign Q_VALID = !rd_empty_q;
`else
    logic [DWO-1:0] q_p1;
    logic           vld_p1;

    // Read stage p1: Q holds its value across rejected or idle cycles.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            q_p1   <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= rd_acc;
            if (rd_acc) begin
                q_p1 <= rd_word;
            end
        end
    end

    assign Q       = q_p1;
    assign Q_VALID = vld_p1;
`endif

endmodule
